data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 32-bit words in the attached data memory; legal word index is 0..MEM_WORDS-1.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req0 / req1  input  1  access request from port 0 / port 1; held high with stable we/addr/wdata until matching ack.
REQ-005 we0 / we1  input  1  1 = write, 0 = read.
REQ-006 addr0 / addr1  input  32  byte address; word index = addr[31:2].
REQ-007 wdata0 / wdata1  input  32  write data.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse to port 0 / port 1.
REQ-009 err0 / err1  output  1  error flag, valid only while the matching ack is high.
REQ-010 rdata0 / rdata1  output  32  read data, valid while the matching ack is high.
REQ-011 mem_read / mem_write  output  1  read and write enables to the data memory.
REQ-012 mem_addr / mem_wdata  output  32  address and write data to the data memory.
REQ-013 mem_rdata  input  32  combinational read data from the data memory.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; the block SHALL hold the state, grant, and captured request in registers.
REQ-016 IDLE: with no req, remain IDLE; with any req high, register the winner's port/we/addr/wdata and go to ACCESS next cycle.
REQ-017 Arbitration: when only one req is high, grant that port; when both are high, grant the port not granted last (round-robin).
REQ-018 The last-grant pointer SHALL update only on a grant.
REQ-019 ACCESS: last exactly 1 cycle, then go to RESP.
REQ-020 ACCESS: drive mem_addr = captured addr.
REQ-021 ACCESS: drive mem_read = ~we and mem_write = we, unless the request is illegal.
REQ-022 ACCESS: drive mem_wdata = captured wdata on writes, 0 otherwise.
REQ-023 Outside ACCESS, mem_read = mem_write = 0 and mem_addr = mem_wdata = 0.
REQ-024 Illegal request: addr[1:0] != 0 or addr[31:2] >= MEM_WORDS.
REQ-025 For an illegal request, mem_read and mem_write SHALL stay 0 for the whole transaction, and the matching err SHALL be 1 in RESP.
REQ-026 End of ACCESS, legal read: capture mem_rdata into the granted port's rdata.
REQ-027 End of ACCESS, write or illegal request: load 0 into the granted port's rdata.
REQ-028 The non-granted port's rdata SHALL hold its value.
REQ-029 RESP: assert ack (and err if illegal) for the granted port only, for exactly 1 cycle, then return to IDLE; requests are never sampled in RESP.
REQ-030 Latency: req sampled in IDLE at cycle N gives memory access in cycle N+1 and ack in cycle N+2; maximum throughput is 1 transaction per 3 cycles.
REQ-031 A port whose req is still high in the IDLE cycle after its ack is treated as a new request.
REQ-032 With both ports requesting continuously, grants SHALL strictly alternate; no port waits more than one transaction.
REQ-033 req dropped by a port while its transaction is in ACCESS or RESP SHALL NOT cancel the transaction; ack is still issued.
REQ-034 ack0 and ack1 SHALL never be high in the same cycle; at most one of mem_read/mem_write is high.

Reset
REQ-035 reset_n low at a rising edge: state = IDLE; last-grant = port 1, so port 0 wins the first tie.
REQ-036 On the same reset, all outputs SHALL be 0: ack0/1, err0/1, rdata0/1, mem_*, busy.
REQ-037 Reset in ACCESS or RESP SHALL abort the transaction: no ack issued, and no memory write after the reset edge.
REQ-038 A request held across reset SHALL be re-arbitrated from IDLE after reset_n returns high.

Verification
REQ-039 Single write then read: port 0 writes addr 0x10 data 0xDEADBEEF, then reads 0x10 -> mem_write=1 for 1 cycle with mem_addr=0x10; read ack0 2 cycles after sampling with rdata0=0xDEADBEEF, err0=0.
REQ-040 Simultaneous requests after reset: req0 and req1 both read -> port 0 acked first, port 1 acked 3 cycles later; a further tie grants port 0 again only after port 1 has been served.
REQ-041 Continuous contention: both reqs held high for 12 cycles -> acks alternate 0,1,0,1, spaced 3 cycles apart; ack0 and ack1 never overlap.
REQ-042 Illegal address: port 1 reads addr 0x400 (word 256); separately, port 0 writes addr 0x13 -> mem_read and mem_write stay 0 throughout; matching ack with err=1 and rdata=0.
REQ-043 Reset mid-access: port 0 write to 0x20 with reset_n low during ACCESS -> no ack0; reading 0x20 afterwards returns the prior contents; busy=0 on the cycle after reset.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Purpose : two-port round-robin arbiter in front of a single-ported 32-bit data memory.
// Latency : request sampled in IDLE -> memory access next cycle -> ack one cycle later (3-cycle occupancy).
// Backpress: requesters hold req/we/addr/wdata until their ack; the loser of a tie simply waits in IDLE.
//
// Ports:
//   clock, reset_n            single clock, synchronous active-low reset
//   req/we/addr/wdata 0,1     requester inputs (byte address, word index = addr[31:2])
//   ack/err/rdata 0,1         per-port completion pulse, error flag and read data
//   mem_read/mem_write        memory enables, high only during ACCESS of a legal request
//   mem_addr/mem_wdata        memory address / write data, zero outside ACCESS
//   mem_rdata                 combinational read data from the memory
//   busy                      high whenever a transaction is in flight
`timescale 1ns/1ps
`default_nettype none

module data_mem_arbiter #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        last_grant;   // port granted most recently; the other port wins a tie
    logic        cur_port;
    logic        cur_we;
    logic        cur_illegal;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic        grant_vld;
    logic        grant_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] rdata_load;

    function automatic logic addr_illegal(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (32'(a[31:2]) >= 32'(MEM_WORDS));
    endfunction

    // Single requester wins outright; on a tie the port not granted last wins.
    always_comb begin
        grant_vld  = req0 | req1;
        grant_port = (req0 && req1) ? ~last_grant : req1;
        sel_we     = grant_port ? we1    : we0;
        sel_addr   = grant_port ? addr1  : addr0;
        sel_wdata  = grant_port ? wdata1 : wdata0;
    end

    // Write and illegal requests return zero data.
    assign rdata_load = (!cur_illegal && !cur_we) ? mem_rdata : 32'h0;

    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                mem_addr  = cur_addr;
                mem_wdata = cur_we ? cur_wdata : 32'h0;
                // Gating with reset_n keeps a reset that lands during ACCESS from
                // committing the write on that same clock edge.
                if (!cur_illegal && reset_n) begin
                    mem_read  = ~cur_we;
                    mem_write = cur_we;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                ack0      = ~cur_port;
                ack1      = cur_port;
                err0      = ~cur_port & cur_illegal;
                err1      = cur_port & cur_illegal;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cur_port    <= 1'b0;
            cur_we      <= 1'b0;
            cur_illegal <= 1'b0;
            cur_addr    <= 32'h0;
            cur_wdata   <= 32'h0;
            rdata0      <= 32'h0;
            rdata1      <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                last_grant  <= grant_port;
                cur_port    <= grant_port;
                cur_we      <= sel_we;
                cur_addr    <= sel_addr;
                cur_wdata   <= sel_wdata;
                cur_illegal <= addr_illegal(sel_addr);
            end
            if (state == ACCESS) begin
                if (cur_port) begin
                    rdata1 <= rdata_load;
                end else begin
                    rdata0 <= rdata_load;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps

module tb_data_mem_arbiter;

    localparam int MW = 256;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    always #5 clock = ~clock;

    data_mem_arbiter #(.MEM_WORDS(MW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    // ---------------- attached data memory (preloaded during reset) ----------------
    logic [31:0] mem [MW];
    int          init_cnt = 0;

    always @(posedge clock) begin
        if (init_cnt < MW) begin
            mem[init_cnt[7:0]] <= init_val(init_cnt);
            init_cnt <= init_cnt + 1;
        end else if (mem_write && mem_addr[31:10] == 22'h0) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_addr[31:10] == 22'h0) ? mem[mem_addr[9:2]] : 32'h0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [MW];
    logic        mdl_last;

    function automatic logic illegal(input logic [31:0] a);
        return (a % 4 != 0) || ((a >> 2) >= 32'(MW));
    endfunction

    task automatic model_txn(input logic port, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.port = port;
        if (illegal(a)) begin
            e.err   = 1'b1;
            e.rdata = 32'h0;
        end else if (we) begin
            e.err   = 1'b0;
            e.rdata = 32'h0;
            ref_mem[a[9:2]] = d;
        end else begin
            e.err   = 1'b0;
            e.rdata = ref_mem[a[9:2]];
        end
        sb.push_back(e);
        mdl_last = port;
    endtask

    // ---------------- monitor ----------------
    exp_t        mon_e;
    logic [31:0] hold0 = 32'h0;
    logic [31:0] hold1 = 32'h0;

    always @(negedge clock) begin
        if (!reset_n) begin
            hold0 = 32'h0;
            hold1 = 32'h0;
        end else begin
            if (mem_read || mem_write) begin
                check("mem_one_hot", {mem_read, mem_write} == 2'b11, 0);
                check("mem_access_legal", illegal(mem_addr), 0);
            end
            if (ack0 || ack1) begin
                check("ack_overlap", {ack0, ack1} == 2'b11, 0);
                check("scoreboard_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("ack_port", ack1, mon_e.port);
                    if (ack1) begin
                        check("err1", err1, mon_e.err);
                        check("rdata1", rdata1, mon_e.rdata);
                        check("rdata0_hold", rdata0, hold0);
                        hold1 = rdata1;
                    end else begin
                        check("err0", err0, mon_e.err);
                        check("rdata0", rdata0, mon_e.rdata);
                        check("rdata1_hold", rdata1, hold1);
                        hold0 = rdata0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs();
        check("rst_flags", {ack0, ack1, err0, err1, busy, mem_read, mem_write}, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
    endtask

    // Called at a negedge while the DUT is IDLE.
    task automatic do_round(input logic r0, input logic r1,
                            input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        logic        f, fw, got0, got1;
        logic [31:0] fa, fd;
        int          k, c0, c1;
        f  = (r0 && r1) ? ~mdl_last : r1;
        fw = f ? w1 : w0;
        fa = f ? a1 : a0;
        fd = f ? d1 : d0;
        model_txn(f, fw, fa, fd);
        if (r0 && r1) begin
            if (f) model_txn(1'b0, w0, a0, d0);
            else   model_txn(1'b1, w1, a1, d1);
        end
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        got0 = !r0; got1 = !r1;
        k = 0; c0 = 0; c1 = 0;
        while (!(got0 && got1) && k < 15) begin
            @(negedge clock);
            k++;
            if (k == 1) begin
                check("acc_mem_read", mem_read, !fw && !illegal(fa));
                check("acc_mem_write", mem_write, fw && !illegal(fa));
                check("acc_mem_addr", mem_addr, fa);
                check("acc_mem_wdata", mem_wdata, fw ? fd : 32'h0);
                check("acc_busy", busy, 1);
            end
            if (k == 2) begin
                check("ack_latency", {ack1, ack0}, f ? 2'b10 : 2'b01);
                check("resp_mem_idle", {mem_read, mem_write}, 0);
            end
            if (ack0 && !got0) begin got0 = 1'b1; c0 = k; req0 = 1'b0; end
            if (ack1 && !got1) begin got1 = 1'b1; c1 = k; req1 = 1'b0; end
        end
        check("round_done", {got1, got0}, 2'b11);
        if (r0 && r1) check("tie_gap", (c0 > c1) ? c0 - c1 : c1 - c0, 3);
        @(negedge clock);
    endtask

    task automatic contention(input int n, input logic [31:0] a0, input logic [31:0] a1);
        int cnt, prev, k;
        for (int i = 0; i < n; i++) begin
            if (mdl_last) model_txn(1'b0, 1'b0, a0, 32'h0);
            else          model_txn(1'b1, 1'b0, a1, 32'h0);
        end
        req0 = 1; we0 = 0; addr0 = a0; wdata0 = 0;
        req1 = 1; we1 = 0; addr1 = a1; wdata1 = 0;
        cnt = 0; prev = -1; k = 0;
        while (cnt < n && k < 3 * n + 6) begin
            @(negedge clock);
            k++;
            if (ack0 || ack1) begin
                cnt++;
                if (prev >= 0) check("contention_gap", k - prev, 3);
                prev = k;
                if (cnt == n) begin req0 = 0; req1 = 0; end
            end
        end
        req0 = 0; req1 = 0;
        check("contention_count", cnt, n);
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        if (r == 1) return 32'h400 + 32'($urandom_range(0, 100) * 4);
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    initial begin
        logic [1:0]  v;
        logic [31:0] wd;
        reset_n = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < MW; i++) ref_mem[i] = init_val(i);
        mdl_last = 1'b1;
        repeat (MW + 4) @(negedge clock);
        check_reset_outputs();
        reset_n = 1;
        @(negedge clock);

        // write then read back
        do_round(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        do_round(1, 0, 0, 32'h10, 0, 0, 0, 0);

        // ties straight after reset favour port 0, then alternate
        do_round(1, 1, 0, 32'h10, 0, 0, 32'h44, 0);
        do_round(1, 1, 0, 32'h08, 0, 0, 32'h0C, 0);
        do_round(0, 1, 1, 0, 0, 1, 32'h18, 32'hCAFEF00D);
        do_round(1, 1, 0, 32'h18, 0, 0, 32'h1C, 0);
        do_round(1, 0, 0, 32'h04, 0, 0, 0, 0);
        do_round(1, 1, 0, 32'h14, 0, 0, 32'h18, 0);

        // continuous contention
        contention(4, 32'h20, 32'h24);

        // illegal requests
        do_round(0, 1, 0, 0, 0, 0, 32'h400, 0);
        do_round(1, 0, 1, 32'h13, 32'h12345678, 0, 0, 0);
        do_round(1, 1, 1, 32'h3FD, 32'h1, 0, 32'hFFFF_FFFC, 0);

        // reset while a write is in ACCESS
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'hA5A5_1234;
        @(negedge clock);
        check("pre_reset_access", {busy, mem_write}, 2'b11);
        reset_n = 0;
        @(negedge clock);
        check_reset_outputs();
        reset_n = 1; req0 = 0;
        mdl_last = 1'b1;
        @(negedge clock);
        do_round(1, 0, 0, 32'h20, 0, 0, 0, 0);
        do_round(1, 1, 0, 32'h30, 0, 0, 32'h34, 0);

        // randomized traffic
        repeat (60) begin
            v  = 2'($urandom_range(1, 3));
            wd = $urandom;
            do_round(v[0], v[1],
                     1'($urandom_range(0, 1)), rand_addr(), wd,
                     1'($urandom_range(0, 1)), rand_addr(), ~wd);
        end

        repeat (4) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
